// File: rtl/serial_tx_fsm.sv
// Byte-wide to serial frame transmitter: start bit, 8 data bits LSB first,
// optional parity bit, 1 or 2 stop bits. One bit per clock, line idles high.
module serial_tx_fsm #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1   // legal values: 1 or 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  // Handshake: a byte is accepted on any rising edge where in_valid && in_ready;
  // in_ready is high in IDLE and in the last stop cycle, and never depends on in_valid.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic       HAS_PARITY = (PARITY_EN != 0);
  localparam logic       ODD        = (PARITY_ODD != 0);
  localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       out_q, out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       last_stop;
  logic       accept;

  assign last_stop = (state_q == ST_STOP) && (cnt_q == STOP_LAST);
  assign in_ready  = (state_q == ST_IDLE) || last_stop;
  assign accept    = in_valid && in_ready;

  // out/busy/done are registered versions of the values for the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    out_d    = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_START;
          shift_d  = in_byte;
          parity_d = (^in_byte) ^ ODD;
          cnt_d    = 3'd0;
          out_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        out_d   = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = 3'd0;
        busy_d  = 1'b1;
      end
      ST_DATA: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d = 3'd0;
          if (HAS_PARITY) begin
            state_d = ST_PARITY;
            out_d   = parity_q;
          end else begin
            state_d = ST_STOP;
            done_d  = (STOP_LAST == 3'd0);
          end
        end else begin
          out_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        cnt_d   = 3'd0;
        busy_d  = 1'b1;
        done_d  = (STOP_LAST == 3'd0);
      end
      ST_STOP: begin
        if (last_stop) begin
          cnt_d = 3'd0;
          if (accept) begin
            state_d  = ST_START;
            shift_d  = in_byte;
            parity_d = (^in_byte) ^ ODD;
            out_d    = 1'b0;
            busy_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + 3'd1;
          busy_d = 1'b1;
          done_d = ((cnt_q + 3'd1) == STOP_LAST);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_tx_fsm.md
SERIAL_TX_FSM -- requirements
Module: serial_tx_fsm

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after data bit 7.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop-bit cycles, legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_byte, input, 8 bits: byte to transmit, sampled only on acceptance.
REQ-007 SHALL have port in_valid, input, 1 bit: in_byte is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a byte this cycle.
REQ-009 SHALL have port out, output, 1 bit: serial line, registered, idle-high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is on the line.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-012 SHALL transmit frames at one bit per clk cycle: start (0), data bits 0..7 LSB first, optional parity bit, then STOP_BITS cycles of 1.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-014 SHALL transition IDLE->START on an edge with in_valid && in_ready; otherwise IDLE SHALL hold with out=1.
REQ-015 SHALL transition START->DATA after 1 cycle, and DATA->PARITY (or STOP) after exactly 8 DATA cycles, counted by a 3-bit counter that wraps to 0.
REQ-016 SHALL transition PARITY->STOP after 1 cycle, and leave STOP after STOP_BITS cycles: to START if a byte is accepted on that last edge, else to IDLE.
REQ-017 SHALL capture in_byte into a shift register on acceptance; changes to in_byte after acceptance SHALL NOT affect the frame.
REQ-018 SHALL drive out from a register so it reflects the current state: 0 in START, the current data bit in DATA, the parity bit in PARITY, 1 in STOP/IDLE.
REQ-019 SHALL compute parity as the XOR of the 8 captured bits, XORed with PARITY_ODD.
REQ-020 SHALL drive in_ready combinationally: 1 in IDLE and in the last STOP cycle, 0 otherwise.
REQ-021 SHALL accept back-to-back bytes: an acceptance in the last STOP cycle SHALL put START on the line the next cycle with no idle gap.
REQ-022 SHALL ignore in_valid while in_ready=0; the byte SHALL be accepted on the first edge where both are 1.
REQ-023 SHALL hold busy=1 from the START cycle through the last STOP cycle inclusive, and 0 in IDLE.
REQ-024 SHALL assert done for exactly one cycle, coincident with the last STOP cycle of each frame.
REQ-025 SHALL have a frame length of 10 + PARITY_EN + (STOP_BITS-1) cycles.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE, out=1, busy=0, done=0, counter=0, shift register=0, independent of clk.
REQ-027 SHALL abort any frame in progress when reset_n is asserted mid-frame, with out returning to 1 immediately.
REQ-028 SHALL drive in_ready=1 out of reset; the first edge after reset_n deasserts MAY accept a byte.

Verification
REQ-029 Defaults, in_byte=0xA5 accepted -> out per cycle = 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; done high in the 10th cycle only.
REQ-030 Back-to-back 0x00 then 0xFF, in_valid held high -> out = 0,0x8 zeros,1,0,1x8 ones,1; no idle cycle between frames; done pulses twice, 10 cycles apart.
REQ-031 PARITY_EN=1, PARITY_ODD=0, 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame length 11 cycles.
REQ-032 STOP_BITS=2, 0x3C -> two stop cycles of 1; in_ready=1 and done=1 only in the second stop cycle.
REQ-033 reset_n pulsed low during data bit 4 of 0xF0 -> out=1 and busy=0 asynchronously; after release, the next byte 0x81 transmits a complete, correct frame.
REQ-034 in_valid asserted with in_byte=0x55 while busy, then in_byte changed to 0x11 -> 0x55 is not taken mid-frame; the value present at the first in_ready edge is the one sent.
